// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared pipeline control types and constants
package core_pkg;

  localparam logic [1:0] ST_RUN    = 2'b00;
  localparam logic [1:0] ST_DRAIN  = 2'b01;
  localparam logic [1:0] ST_HALTED = 2'b10;

  typedef enum logic [1:0] {
    RUN    = ST_RUN,
    DRAIN  = ST_DRAIN,
    HALTED = ST_HALTED
  } state_t;

  // addi x0, x0, 0 loaded by pipeline registers when flushed
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - wrapping enable counter with async active-low reset
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (en_i) begin
      cnt_o <= cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - merges stall/flush sources into per-stage controls
// and owns the debug halt/drain FSM, EX-busy watchdog and perf counters.
module pipeline_ctrl
  import core_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int WDOG_CYCLES  = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             hz_pc_en_i,
  input  logic             hz_if_id_en_i,
  input  logic             hz_control_pass_i,
  input  logic             ex_busy_i,
  input  logic             branch_taken_id_i,
  input  logic             halt_req_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_en_o,
  output logic             id_ex_bubble_o,
  output logic             ex_mem_bubble_o,
  output logic             halt_ack_o,
  output logic             wdog_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam int WDOG_W  = $clog2(WDOG_CYCLES + 1);

  state_t             state, state_next;
  logic [DRAIN_W-1:0] drain_cnt, drain_next;
  logic [WDOG_W-1:0]  wdog_cnt;
  logic               hazard;

  assign hazard = !hz_pc_en_i || !hz_if_id_en_i || !hz_control_pass_i;

  always_comb begin
    pc_en_o         = 1'b1;
    if_id_en_o      = 1'b1;
    if_id_flush_o   = 1'b0;
    id_ex_en_o      = 1'b1;
    id_ex_bubble_o  = 1'b0;
    ex_mem_bubble_o = 1'b0;
    state_next      = state;
    drain_next      = drain_cnt;
    case (state)
      RUN: begin
        drain_next = '0;
        if (ex_busy_i) begin
          pc_en_o         = 1'b0;
          if_id_en_o      = 1'b0;
          id_ex_en_o      = 1'b0;
          ex_mem_bubble_o = 1'b1;
        end else if (hazard) begin
          // branch is masked: ID holds a stale instruction until the hazard clears
          pc_en_o        = 1'b0;
          if_id_en_o     = 1'b0;
          id_ex_bubble_o = 1'b1;
        end else if (branch_taken_id_i) begin
          if_id_flush_o = 1'b1;
        end
        if (halt_req_i && !ex_busy_i) state_next = DRAIN;
      end
      DRAIN, HALTED: begin
        pc_en_o        = 1'b0;
        if_id_en_o     = 1'b0;
        if_id_flush_o  = 1'b1;
        id_ex_bubble_o = 1'b1;
        if (!halt_req_i) begin
          state_next = RUN;
          drain_next = '0;
        end else if (state == DRAIN) begin
          if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
            state_next = HALTED;
            drain_next = '0;
          end else begin
            drain_next = drain_cnt + DRAIN_W'(1);
          end
        end
      end
      default: begin
        state_next = RUN;
        drain_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= RUN;
      drain_cnt  <= '0;
      halt_ack_o <= 1'b0;
    end else begin
      state      <= state_next;
      drain_cnt  <= drain_next;
      halt_ack_o <= (state_next == HALTED);
    end
  end

  // Saturating run-length of ex_busy_i; the error flag is sticky until reset
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_cnt   <= '0;
      wdog_err_o <= 1'b0;
    end else if (!ex_busy_i) begin
      wdog_cnt <= '0;
    end else begin
      if (wdog_cnt != WDOG_W'(WDOG_CYCLES)) wdog_cnt <= wdog_cnt + WDOG_W'(1);
      if (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1)) wdog_err_o <= 1'b1;
    end
  end

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk    (clk),
    .rst_ni (rst_ni),
    .en_i   ((state == RUN) && !pc_en_o),
    .cnt_o  (stall_cnt_o)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk    (clk),
    .rst_ni (rst_ni),
    .en_i   (if_id_flush_o),
    .cnt_o  (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        hz_pc_en, hz_if_id_en, hz_control_pass;
  logic        ex_busy, branch_taken_id, halt_req;
  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_bubble;
  logic        halt_ack, wdog_err;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.DRAIN_CYCLES(4), .WDOG_CYCLES(64), .CNT_W(32)) dut (
    .clk               (clk),
    .rst_ni            (rst_ni),
    .hz_pc_en_i        (hz_pc_en),
    .hz_if_id_en_i     (hz_if_id_en),
    .hz_control_pass_i (hz_control_pass),
    .ex_busy_i         (ex_busy),
    .branch_taken_id_i (branch_taken_id),
    .halt_req_i        (halt_req),
    .pc_en_o           (pc_en),
    .if_id_en_o        (if_id_en),
    .if_id_flush_o     (if_id_flush),
    .id_ex_en_o        (id_ex_en),
    .id_ex_bubble_o    (id_ex_bubble),
    .ex_mem_bubble_o   (ex_mem_bubble),
    .halt_ack_o        (halt_ack),
    .wdog_err_o        (wdog_err),
    .stall_cnt_o       (stall_cnt),
    .flush_cnt_o       (flush_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hz_pc_en        = 1'b1;
    hz_if_id_en     = 1'b1;
    hz_control_pass = 1'b1;
    ex_busy         = 1'b0;
    branch_taken_id = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0;
    halt_req = 1'b0;
    idle_inputs();
    #12;
    check_eq("rst_pc_en", pc_en, 1);
    check_eq("rst_if_id_en", if_id_en, 1);
    check_eq("rst_id_ex_en", id_ex_en, 1);
    check_eq("rst_flush", if_id_flush, 0);
    check_eq("rst_bubbles", {id_ex_bubble, ex_mem_bubble}, 0);
    check_eq("rst_ack", halt_ack, 0);
    check_eq("rst_wdog", wdog_err, 0);
    check_eq("rst_cnts", stall_cnt | flush_cnt, 0);
    cyc();
    rst_ni = 1'b1;

    // load-use stall
    {hz_pc_en, hz_if_id_en, hz_control_pass} = 3'b000;
    #1;
    check_eq("lu_pc_en", pc_en, 0);
    check_eq("lu_if_id_en", if_id_en, 0);
    check_eq("lu_bubble", id_ex_bubble, 1);
    cyc();
    idle_inputs();
    check_eq("lu_stall_cnt", stall_cnt, 1);

    // branch masked by hazard, then taken
    hz_pc_en = 1'b0;
    branch_taken_id = 1'b1;
    #1;
    check_eq("br_hz_flush", if_id_flush, 0);
    cyc();
    hz_pc_en = 1'b1;
    #1;
    check_eq("br_flush", if_id_flush, 1);
    check_eq("br_pc_en", pc_en, 1);
    cyc();
    idle_inputs();
    check_eq("br_flush_cnt", flush_cnt, 1);
    check_eq("br_stall_cnt", stall_cnt, 2);

    // DIV busy 10 cycles overriding hazard and branch
    ex_busy = 1'b1;
    {hz_pc_en, hz_if_id_en, hz_control_pass} = 3'b000;
    branch_taken_id = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq("busy_id_ex_en", id_ex_en, 0);
      check_eq("busy_ex_mem_bubble", ex_mem_bubble, 1);
      check_eq("busy_flush", if_id_flush, 0);
      cyc();
    end
    idle_inputs();
    check_eq("busy_stall_cnt", stall_cnt, 12);
    check_eq("busy_flush_cnt", flush_cnt, 1);
    check_eq("busy_wdog", wdog_err, 0);

    // halt: drain 4 cycles, ack from cycle 5, resume
    halt_req = 1'b1;
    #1;
    check_eq("h0_pc_en", pc_en, 1);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check_eq("drain_pc_en", pc_en, 0);
      check_eq("drain_flush", if_id_flush, 1);
      check_eq("drain_bubble", id_ex_bubble, 1);
      check_eq("drain_ack", halt_ack, 0);
    end
    cyc();
    check_eq("halted_ack", halt_ack, 1);
    check_eq("halted_pc_en", pc_en, 0);
    halt_req = 1'b0;
    #1;
    check_eq("halted_hold_pc_en", pc_en, 0);
    cyc();
    check_eq("resume_ack", halt_ack, 0);
    check_eq("resume_pc_en", pc_en, 1);
    check_eq("halt_flush_cnt", flush_cnt, 6);
    check_eq("halt_stall_cnt", stall_cnt, 12);

    // drain aborted, then full halt again must take the full 4 drain cycles
    halt_req = 1'b1;
    cyc();
    cyc();
    halt_req = 1'b0;
    cyc();
    check_eq("abort_pc_en", pc_en, 1);
    check_eq("abort_flush_cnt", flush_cnt, 8);
    halt_req = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    check_eq("redrain_ack_early", halt_ack, 0);
    cyc();
    check_eq("redrain_ack", halt_ack, 1);
    halt_req = 1'b0;
    cyc();
    check_eq("redrain_flush_cnt", flush_cnt, 13);

    // halt pending while busy
    halt_req = 1'b1;
    ex_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("hb_pc_en", pc_en, 0);
      check_eq("hb_ex_mem_bubble", ex_mem_bubble, 1);
      check_eq("hb_flush", if_id_flush, 0);
      cyc();
    end
    ex_busy = 1'b0;
    #1;
    check_eq("hb_run_flush", if_id_flush, 0);
    check_eq("hb_run_pc_en", pc_en, 1);
    cyc();
    check_eq("hb_drain_flush", if_id_flush, 1);
    check_eq("hb_stall_cnt", stall_cnt, 15);
    halt_req = 1'b0;
    cyc();
    check_eq("hb_flush_cnt", flush_cnt, 14);

    // watchdog
    ex_busy = 1'b1;
    for (int i = 0; i < 63; i++) cyc();
    check_eq("wdog_63", wdog_err, 0);
    cyc();
    check_eq("wdog_64", wdog_err, 1);
    ex_busy = 1'b0;
    cyc();
    check_eq("wdog_sticky", wdog_err, 1);
    check_eq("wdog_stall_cnt", stall_cnt, 79);

    // async reset mid-HALTED
    halt_req = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    check_eq("pre_rst_ack", halt_ack, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("arst_ack", halt_ack, 0);
    check_eq("arst_wdog", wdog_err, 0);
    check_eq("arst_stall_cnt", stall_cnt, 0);
    check_eq("arst_flush_cnt", flush_cnt, 0);
    check_eq("arst_pc_en", pc_en, 1);
    halt_req = 1'b0;
    cyc();
    rst_ni = 1'b1;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
